// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - b_in, LSB first; SERIAL_SUB_OVF_EN adds a signed-overflow flag
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc_nx;
  logic [WIDTH-2:0] acc;
  logic [CW-1:0] cnt;
  logic bor, ai, bi, d, bor_nx, last;
  always_comb begin
    ai = a_sh[0];
    bi = b_sh[0];
    d = ai ^ bi ^ bor;
    bor_nx = (~ai & bi) | (~(ai ^ bi) & bor);
    acc_nx = {d, acc};
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // acc only keeps the WIDTH-1 bits that survive into the final result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      cnt <= '0;
      bor <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh <= a;
        b_sh <= b;
        bor <= b_in;
        cnt <= '0;
        acc <= '0;
      end
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      bor <= bor_nx;
      acc <= acc_nx[WIDTH-1:1];
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= acc_nx;
        borrow <= bor_nx;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == SHIFT && last)
      ovf <= (a_msb != b_msb) && (d != a_msb);
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of serial_subtractor against a latency/arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst_n, start, b_in, busy, done, borrow;
  logic [W-1:0] a, b, diff;
  int total = 0, bad = 0, cyc = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // model: remaining busy cycles after acceptance, result published on entry to the done cycle
  int m_left;
  logic [W-1:0] m_diff, p_diff;
  logic m_bor, p_bor, m_ovf, p_ovf;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left = 0; m_diff = '0; m_bor = 1'b0; m_ovf = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = W + 1;
        p_diff = a - b - W'(b_in);
        p_bor = int'(a) < int'(b) + int'(b_in);
        p_ovf = (a[W-1] != b[W-1]) && (p_diff[W-1] != a[W-1]);
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_diff = p_diff; m_bor = p_bor; m_ovf = p_ovf;
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_left == 1);
      check("diff", diff, m_diff);
      check("borrow", borrow, m_bor);
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", ovf, m_ovf);
`endif
    end
  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("done_seen", done, 1);
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input logic [W-1:0] ed, input logic eb);
    @(negedge clk);
    a = x; b = y; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("lit_diff", diff, ed);
    check("lit_borrow", borrow, eb);
    @(negedge clk);
  endtask
  int c0, n_done;
  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; c0 = cyc;
    wait_done();
    check("latency", cyc - c0, W);
    check("t1_diff", diff, 8'h1E);
    check("t1_borrow", borrow, 0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
    // start pulses during SHIFT and DONE must be ignored
    a = 8'h5A; b = 8'h3C; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("t3_diff", diff, 8'h1E);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_idle", busy, 0);
    @(negedge clk);
    check("t3_still_idle", busy, 0);
    // asynchronous reset mid-operation
    a = 8'h77; b = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
    // start held high: back-to-back operations
    a = 8'h80; b = 8'h7F; b_in = 1'b0; start = 1'b1; n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("t5_diff", diff, 8'h01);
        check("t5_borrow", borrow, 0);
      end
    end
    start = 1'b0;
    check("t5_count", n_done, 3);
    repeat (12) @(negedge clk);
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    check("t6_ovf1", ovf, 1);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    check("t6_ovf0", ovf, 0);
`endif
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 1'b0;
        #1 check("rnd_arst_busy", busy, 0);
        #1 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor that computes a - b - b_in one bit per clock, LSB first, using the full-subtractor cell equations.
- A borrow flip-flop carries the borrow between bit slices.
- Sits upstream of result consumers: the operand source pulses start, and the block later pulses done with a registered difference and final borrow.
- Trades WIDTH cycles of latency for a single subtractor cell.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
b_in  input  1  initial borrow-in; sampled on the accepting edge only
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  registered difference; held until next completion
borrow  output  1  registered final borrow-out; held until next completion

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low. rst_n=0 immediately forces the following, from any state including mid-operation:
  - state=IDLE; busy=0; done=0; diff=0; borrow=0
  - shift registers, bit counter and borrow flip-flop cleared
  - a partial result is discarded, never published
- States: IDLE, SHIFT, DONE (Moore outputs).
- IDLE:
  - start=1 at a rising edge loads a_sh<=a, b_sh<=b, bor<=b_in, cnt<=0, acc<=0, and moves to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge, with ai=a_sh[0], bi=b_sh[0]:
  - d = ai ^ bi ^ bor
  - bor <= (~ai & bi) | (~(ai ^ bi) & bor)
  - acc <= {d, acc[WIDTH-1:1]} (right shift, MSB-in)
  - a_sh, b_sh shift right one bit; cnt <= cnt+1
  - On the edge where cnt==WIDTH-1: diff <= final shifted acc value, borrow <= final borrow, state -> DONE.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: done is high in the cycle after the WIDTH-th shift edge, i.e. WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles.
- busy=1 in SHIFT and DONE.
- start while busy (SHIFT or DONE) is ignored; no queuing. Operands and b_in may change freely while busy.
- diff and borrow change only at the completing edge, so they are stable throughout SHIFT and after DONE.
- start held high continuously: a new operation is accepted on every IDLE visit.
- Arithmetic: result is (a - b - b_in) mod 2^WIDTH. borrow=1 iff a < b + b_in as unsigned values.
- cnt width is clog2(WIDTH)+1 bits so that it never wraps before completion.

Optional Feature:
Macro: SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), reset to 0.
  - ovf is loaded together with diff as (a_msb != b_msb) && (d_msb != a_msb), using the sampled a and b MSBs and the final difference MSB. This flags signed two's-complement overflow.
  - ovf is held until the next completion.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8.
1. a=0x5A, b=0x3C, b_in=0, start pulse -> done exactly 8 edges after the accepting edge; diff=0x1E, borrow=0; busy=1 for 9 cycles.
2. a=0x00, b=0x01, b_in=0 -> diff=0xFF, borrow=1. Then a=0x10, b=0x10, b_in=1 -> diff=0xFF, borrow=1. Then a=0xFF, b=0x00, b_in=1 -> diff=0xFE, borrow=0.
3. Start a=0x5A, b=0x3C; pulse start with a=0x01, b=0x01 on the 3rd SHIFT cycle and again in the DONE cycle -> both pulses are ignored; result is 0x1E; busy drops after DONE.
4. Start an operation; assert rst_n=0 asynchronously after 4 shift edges -> busy, done, diff and borrow go to 0 immediately without waiting for an edge. Release reset, run a=0x33, b=0x11 -> diff=0x22, borrow=0; no stale done pulse.
5. start held high for 30 cycles, a=0x80, b=0x7F -> back-to-back operations every 10 cycles; each completion gives done=1, diff=0x01, borrow=0.
6. With SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0. Then a=0x05, b=0x03 -> diff=0x02, ovf=0.
